rv_fifo: RTL and testbench

- Ready/valid elastic buffer that sits directly downstream of the pipeline stage and consumes its ds_* output.
- Absorbs bursts when the sink throttles ds_ready, for example with pseudo-random backpressure.
- Decouples the backpressure timing: ds_ready has no combinational path to us_ready.
- Storage is a power-of-two ring buffer indexed by wrap-bit pointers.

---
 rtl/rv_pkg.sv | 8 +
 rtl/rv_fifo_mem.sv | 25 ++
 rtl/rv_fifo.sv | 95 +++++++++
 tb/tb_rv_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared ready/valid definitions used by the pipeline stage and the rv_fifo buffer.
package rv_pkg;

  localparam int RV_WIDTH = 16;

  typedef logic [RV_WIDTH-1:0] rv_data_t;

endpackage : rv_pkg

// File: rtl/rv_fifo_mem.sv
// Register-array storage for rv_fifo: synchronous write, combinational read, no reset.
module rv_fifo_mem
  import rv_pkg::*;
#(
  parameter int WIDTH = RV_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : rv_fifo_mem

// File: rtl/rv_fifo.sv
// Ready/valid elastic buffer on a power-of-two ring with wrap-bit pointers.
// Define RV_FIFO_CHECK_EN to compile in handshake/occupancy protocol assertions.
module rv_fifo
  import rv_pkg::*;
#(
  parameter  int WIDTH = RV_WIDTH,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] us_data,
  input  logic             us_valid,
  output logic             us_ready,
  output logic [WIDTH-1:0] ds_data,
  output logic             ds_valid,
  input  logic             ds_ready,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  // Both flags come from registered pointers only, so ds_ready never reaches us_ready.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign us_ready = !full;
  assign ds_valid = !empty;
  assign push     = us_valid && us_ready;
  assign pop      = ds_valid && ds_ready;
  assign ds_data  = empty ? '0 : rdata;

  rv_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (us_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RV_FIFO_CHECK_EN
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic             hold_q;
  logic [WIDTH-1:0] ds_data_q;

  always_ff @(posedge clock) begin
    ds_data_q <= ds_data;
  end

  // hold_q marks a head word that was presented but not taken on the previous edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= ds_valid && !ds_ready;
      if (push && !(count < DEPTH_C))
        $error("rv_fifo: push while full at %0t", $time);
      if (pop && !(count > '0))
        $error("rv_fifo: pop while empty at %0t", $time);
      if (count != (wr_ptr - rd_ptr))
        $error("rv_fifo: count disagrees with pointers at %0t", $time);
      if (hold_q && (ds_data != ds_data_q))
        $error("rv_fifo: head word changed while stalled at %0t", $time);
    end
  end
`endif

endmodule : rv_fifo

// File: tb/tb_rv_fifo.sv
// Self-checking bench for rv_fifo: queue-based reference model plus directed and random traffic.
module tb_rv_fifo;
  import rv_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] us_data;
  logic             us_valid;
  logic             us_ready;
  logic [WIDTH-1:0] ds_data;
  logic             ds_valid;
  logic             ds_ready;
  logic [AW:0]      count;

  int n_chk;
  int n_fail;

  rv_data_t mq[$];
  bit       m_push;
  bit       m_pop;

  rv_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .us_data  (us_data),
    .us_valid (us_valid),
    .us_ready (us_ready),
    .ds_data  (ds_data),
    .ds_valid (ds_valid),
    .ds_ready (ds_ready),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: the FIFO is just a bounded queue of accepted words.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      m_pop  = ds_ready && (mq.size() > 0);
      m_push = us_valid && (mq.size() < DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(us_data);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("ds_valid", 32'(ds_valid), 32'(mq.size() != 0));
      chk("ds_data", 32'(ds_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("us_ready", 32'(us_ready), 32'(mq.size() < DEPTH));
      chk("count", 32'(count), 32'(mq.size()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time 100000 exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    bit r;
    logic [31:0] scr;
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b0;
    us_valid = 1'b0;
    us_data  = '0;
    ds_ready = 1'b0;

    // Test 1: reset then idle
    #2 reset = 1'b1;
    #1;
    chk("rst_us_ready", 32'(us_ready), 32'h1);
    chk("rst_ds_valid", 32'(ds_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ds_data", 32'(ds_data), 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("idle_us_ready", 32'(us_ready), 32'h1);
    chk("idle_ds_valid", 32'(ds_valid), 32'h0);
    chk("idle_count", 32'(count), 32'h0);
    chk("idle_ds_data", 32'(ds_data), 32'h0);

    // Test 2: fill with sink stalled, fifth word held off, then drain
    for (int i = 0; i < 4; i++) begin
      us_valid = 1'b1;
      us_data  = 16'h1000 + 16'(i);
      step();
    end
    us_data = 16'h1004;
    step();
    step();
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_us_ready", 32'(us_ready), 32'h0);
    chk("fill_head", 32'(ds_data), 32'h1000);
    us_valid = 1'b0;
    ds_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_count", 32'(count), 32'(3 - k));
    end

    // Test 3: streaming push+pop every cycle across several wraps
    us_valid = 1'b1;
    ds_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      us_data = 16'(i);
      step();
      chk("stream_count", 32'(count), 32'h1);
    end
    chk("stream_last", 32'(ds_data), 32'h0013);
    us_valid = 1'b0;
    step();
    chk("stream_empty", 32'(count), 32'h0);

    // Test 4: full with simultaneous pop
    ds_ready = 1'b0;
    us_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      us_data = 16'h4000 + 16'(i);
      step();
    end
    us_data  = 16'h4004;
    ds_ready = 1'b1;
    step();
    chk("fullpop_count", 32'(count), 32'h3);
    chk("fullpop_head", 32'(ds_data), 32'h4001);
    step();
    chk("fullpush_count", 32'(count), 32'h3);
    us_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("full_drained", 32'(count), 32'h0);

    // Test 5: random backpressure, sparse upstream
    pend = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pend && us_ready) pend = 1'b0;
      if (!pend && (cyc % 8 == 0)) begin
        pend    = 1'b1;
        us_data = 16'(cyc);
      end
      us_valid = pend;
      scr = $urandom ^ (32'(cyc) * 32'h9E3779B1);
      r   = scr[0];
      ds_ready = ~r;
      #2;
      chk("rand_us_ready_indep", 32'(us_ready), 32'(mq.size() < DEPTH));
      ds_ready = r;
      chk("rand_count_max", 32'(count <= 3'(DEPTH)), 32'h1);
      step();
    end
    us_valid = 1'b0;
    ds_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rand_drained", 32'(count), 32'h0);

    // Test 6: asynchronous reset mid-operation
    ds_ready = 1'b0;
    us_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      us_data = 16'h6000 + 16'(i);
      step();
    end
    us_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("async_ds_valid", 32'(ds_valid), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_us_ready", 32'(us_ready), 32'h1);
    step();
    reset = 1'b0;
    us_valid = 1'b1;
    us_data  = 16'hBEEF;
    step();
    us_valid = 1'b0;
    chk("post_rst_head", 32'(ds_data), 32'hBEEF);
    chk("post_rst_count", 32'(count), 32'h1);
    ds_ready = 1'b1;
    step();
    chk("post_rst_empty", 32'(ds_valid), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_rv_fifo
